// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, bubble word,
// FSM state encoding and the IF/ID payload struct.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [XLEN-1:0] DEF_NOP_WORD     = 32'h0000_0000;  // sll $0,$0,0

    // FSM state encoding
    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus_four;
        logic            valid;
    } if_id_t;

    // Redirect targets are word addresses; the two low bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its environment (hazard unit, decode, imem).
//  master : environment side - drives control/redirect/halt and imem_data
//  slave  : fetch_stage side - drives imem_addr, pc_F and the IF/ID outputs
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            stall_F;
    logic            stall_D;
    logic            flush_D;
    logic            jump;
    logic [XLEN-1:0] jump_address;
    logic            halt;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_data;
    logic [XLEN-1:0] pc_F;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus_four;
    logic            valid_D;
    logic            halted;

    modport master (
        output stall_F, stall_D, flush_D, jump, jump_address, halt, imem_data,
        input  imem_addr, pc_F, instruction, pc_plus_four, valid_D, halted
    );

    modport slave (
        input  stall_F, stall_D, flush_D, jump, jump_address, halt, imem_data,
        output imem_addr, pc_F, instruction, pc_plus_four, valid_D, halted
    );

endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register with flush (highest priority), stall (hold) and load.
// Ports:
//  clk_i, rst_i : clock, asynchronous active-high reset (loads the bubble)
//  flush_i      : load the bubble {NOP_WORD, 0, valid 0}
//  stall_i      : hold current contents
//  d_i          : payload loaded when neither flush nor stall
//  q_o          : registered payload
module fetch_stage_if_id
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   stall_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    localparam if_id_t BUBBLE = '{NOP_WORD, 32'h0, 1'b0};

    if_id_t reg_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_q <= BUBBLE;
        end else if (flush_i) begin
            reg_q <= BUBBLE;
        end else if (!stall_i) begin
            reg_q <= d_i;
        end
    end

    assign q_o = reg_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address, applies decode
// redirects and hazard-unit stall/flush, and feeds decode through the IF/ID register.
// No delay slot: a taken redirect squashes the word fetched behind it.
// Ports:
//  clk_i, rst_i : clock, asynchronous active-high reset
//  bus (slave)  : stall_F/stall_D/flush_D, jump/jump_address, halt, imem_addr/imem_data,
//                 pc_F, instruction, pc_plus_four, valid_D, halted
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] NOP_WORD     = DEF_NOP_WORD
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_stage_if.slave  bus
);

    localparam if_id_t BUBBLE = '{NOP_WORD, 32'h0, 1'b0};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            if_flush;
    logic            if_stall;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    // State, PC and halted flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_VECTOR;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // Next-state, next-PC and IF/ID control
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        if_flush = 1'b1;  // BOOT and HALTED keep IF/ID a bubble
        if_stall = 1'b0;
        if_id_d  = '{bus.imem_data, pc_q + XLEN'(4), 1'b1};

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.halt) begin
                    // PC freezes and the word in IF/ID is squashed on the halt edge
                    state_d = ST_HALTED;
                end else begin
                    if_flush = bus.flush_D;
                    if_stall = bus.stall_D;
                    if (bus.jump) begin
                        if_id_d = BUBBLE;
                    end
                    // A jump under stall_D is stale; the hazard unit re-presents it
                    if (!bus.stall_F) begin
                        if (bus.jump && !bus.stall_D) begin
                            pc_d = word_align(bus.jump_address);
                        end else begin
                            pc_d = pc_q + XLEN'(4);
                        end
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase

        halted_d = (state_d == ST_HALTED);
    end

    fetch_stage_if_id #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (if_flush),
        .stall_i (if_stall),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign bus.imem_addr    = pc_q;
    assign bus.pc_F         = pc_q;
    assign bus.instruction  = if_id_q.instruction;
    assign bus.pc_plus_four = if_id_q.pc_plus_four;
    assign bus.valid_D      = if_id_q.valid;
    assign bus.halted       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized control traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RV  = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Synthetic instruction memory: distinct word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 boot, 1 running, 2 halted
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ppf;
    logic        m_valid;

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = RV;
        m_instr = NOP;
        m_ppf   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] npc, ni, np;
        logic        nv;
        int          nm;
        npc = m_pc; ni = m_instr; np = m_ppf; nv = m_valid; nm = m_mode;
        if (m_mode == 0) begin
            nm = 1;
        end else if (m_mode == 1 && bus.halt) begin
            nm = 2; ni = NOP; np = 32'h0; nv = 1'b0;
        end else if (m_mode == 1) begin
            if (!bus.stall_F) begin
                if (bus.jump && !bus.stall_D) npc = {bus.jump_address[31:2], 2'b00};
                else                          npc = m_pc + 32'd4;
            end
            if (bus.flush_D) begin
                ni = NOP; np = 32'h0; nv = 1'b0;
            end else if (bus.stall_D) begin
                // IF/ID holds
            end else if (bus.jump) begin
                ni = NOP; np = 32'h0; nv = 1'b0;
            end else begin
                ni = mem_word(m_pc); np = m_pc + 32'd4; nv = 1'b1;
            end
        end else begin
            ni = NOP; np = 32'h0; nv = 1'b0;
        end
        m_pc = npc; m_instr = ni; m_ppf = np; m_valid = nv; m_mode = nm;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pc_F"},         bus.pc_F,                m_pc);
        check({ctx, ".imem_addr"},    bus.imem_addr,           m_pc);
        check({ctx, ".instruction"},  bus.instruction,         m_instr);
        check({ctx, ".pc_plus_four"}, bus.pc_plus_four,        m_ppf);
        check({ctx, ".valid_D"},      32'(bus.valid_D),        32'(m_valid));
        check({ctx, ".halted"},       32'(bus.halted),         32'(m_mode == 2));
    endtask

    // One clock: model advances on the same inputs, outputs sampled 1 time unit later
    task automatic tick(input string ctx);
        model_step();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    // Reset pulse placed between clock edges; outputs must settle before the next edge
    task automatic do_reset(input string ctx);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(ctx);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.stall_F = 1'b0; bus.stall_D = 1'b0; bus.flush_D = 1'b0;
        bus.jump = 1'b0; bus.jump_address = 32'h0; bus.halt = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle_inputs();
        do_reset("reset");
        check("reset.pc_const", bus.pc_F, RV);

        // Straight-line fetch
        tick("boot");
        check("boot.valid_const", 32'(bus.valid_D), 32'h0);
        for (int i = 0; i < 3; i++) tick("seq");
        check("seq.pc_const", bus.pc_F, 32'h0040_000C);
        check("seq.instr_const", bus.instruction, mem_word(32'h0040_0008));

        // Redirect from 0x0040000C
        bus.jump = 1'b1; bus.jump_address = 32'h0040_0100;
        tick("jump");
        check("jump.pc_const", bus.pc_F, 32'h0040_0100);
        bus.jump = 1'b0;
        tick("jump_after");
        check("jump_after.instr_const", bus.instruction, mem_word(32'h0040_0100));

        // Stall both stages with a pending jump
        bus.stall_F = 1'b1; bus.stall_D = 1'b1;
        bus.jump = 1'b1; bus.jump_address = 32'h0040_0203;
        for (int i = 0; i < 3; i++) tick("stall");
        bus.stall_F = 1'b0; bus.stall_D = 1'b0;
        tick("stall_release");
        check("stall_release.pc_const", bus.pc_F, 32'h0040_0200);
        bus.jump = 1'b0;
        tick("post_jump");

        // Flush overrides stall_D; PC follows stall_F
        bus.flush_D = 1'b1; bus.stall_D = 1'b1; bus.stall_F = 1'b1;
        tick("flush_stallF");
        bus.stall_F = 1'b0;
        tick("flush_nostallF");
        idle_inputs();
        tick("flush_after");

        // PC wrap-around
        bus.jump = 1'b1; bus.jump_address = 32'hFFFF_FFFC;
        tick("wrap_jump");
        bus.jump = 1'b0;
        tick("wrap");
        check("wrap.pc_const", bus.pc_F, 32'h0);
        check("wrap.ppf_const", bus.pc_plus_four, 32'h0);
        tick("wrap_after");

        // Mid-cycle async reset
        do_reset("midreset");
        check("midreset.pc_const", bus.pc_F, RV);
        for (int i = 0; i < 4; i++) tick("restart");

        // Halt: absorbing, jumps ignored
        bus.halt = 1'b1;
        tick("halt");
        check("halt.halted_const", 32'(bus.halted), 32'h1);
        bus.halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.jump = 1'($urandom_range(0, 1));
            bus.jump_address = $urandom;
            tick("halted");
        end
        idle_inputs();
        do_reset("halt_reset");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                idle_inputs();
                do_reset("rnd_reset");
            end else begin
                bus.stall_F      = ($urandom_range(0, 3) == 0);
                bus.stall_D      = ($urandom_range(0, 3) == 0);
                bus.flush_D      = ($urandom_range(0, 7) == 0);
                bus.jump         = ($urandom_range(0, 4) == 0);
                bus.jump_address = $urandom;
                bus.halt         = ($urandom_range(0, 199) == 0);
                tick("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
